// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple CPU and its data-memory responder:
// default bus widths and the responder's FSM state encoding.
package simple_cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/simple_cpu_ram_sp.sv
// Single-port RAM: one write port, registered read data, read-before-write.
// The read register holds its value whenever no read is requested.
module simple_cpu_ram_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset branch here would turn it into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Sampling mem in the same edge as the write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/simple_cpu_dmem.sv
// Data-memory responder for simple_cpu_top: clears the array after reset,
// accepts an optional preload stream, then serves CPU reads and writes.
module simple_cpu_dmem
    import simple_cpu_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] dm_abus,
    input  logic [DATA_W-1:0] dm_out_dbus,
    output logic [DATA_W-1:0] dm_in_dbus,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_hold
);

    dmem_state_t       state, state_next;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_next;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state    <= state_next;
            clr_cnt  <= clr_cnt_next;
            ld_ready <= (state_next == ST_LOAD);
            cpu_hold <= (state_next != ST_RUN);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = dm_abus;
        ram_wdata    = dm_out_dbus;

        unique case (state)
            ST_CLEAR: begin
                ram_we       = 1'b1;
                ram_addr     = clr_cnt[ADDR_W-1:0];
                ram_wdata    = CLEAR_VAL;
                clr_cnt_next = clr_cnt + (ADDR_W+1)'(1);
                // The extra counter bit sets exactly after the last word is written.
                if (clr_cnt_next[ADDR_W]) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ram_we    = ld_valid;
                ram_addr  = ld_addr;
                ram_wdata = ld_data;
                if (ld_valid && ld_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we = wr_mem;
                ram_re = rd_mem;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase

        // A write coinciding with reset is dropped; the clear pass follows anyway.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    simple_cpu_ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (dm_in_dbus)
    );

endmodule
